// File: rtl/ram_io_responder.sv
// Byte-wide RAM responder with a memory-mapped TX FIFO and an RX byte port.
// It returns read data one cycle after the address and holds off TX stores while the FIFO is full.
module ram_io_responder #(
    parameter int unsigned RAM_AW      = 17,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [31:0] IO_IN_ADDR  = 32'h0003_0000,
    parameter logic [31:0] IO_END_ADDR = 32'h0003_0004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_a,
    input  logic        mem_wr,
    input  logic [7:0]  mem_dout,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        program_finish
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(FIFO_DEPTH);

    logic [7:0]        ram [0:(1 << RAM_AW) - 1];
    logic [7:0]        fifo_mem [0:FIFO_DEPTH - 1];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              prev_rx_read;

    logic              is_io;
    logic [RAM_AW-1:0] ram_idx;
    logic              hit_in;
    logic              push;
    logic              pop;
    logic              rx_read;

    always_comb begin
        is_io          = (mem_a[17:16] == 2'b11);
        ram_idx        = mem_a[RAM_AW-1:0];
        hit_in         = (mem_a == IO_IN_ADDR);
        io_buffer_full = (count == FULL_COUNT);
        tx_valid       = (count != '0);
        tx_data        = fifo_mem[rd_ptr];
        push           = mem_wr && hit_in && !io_buffer_full;
        pop            = tx_valid && tx_ready;
        rx_read        = !mem_wr && hit_in;
    end

    // Storage arrays carry no reset; only the pointers and count define FIFO state.
    always_ff @(posedge clk) begin
        if (mem_wr && !is_io)
            ram[ram_idx] <= mem_dout;
        if (push)
            fifo_mem[wr_ptr] <= mem_dout;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_din        <= '0;
            rx_ready       <= 1'b0;
            program_finish <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            prev_rx_read   <= 1'b0;
        end else begin
            if (!mem_wr) begin
                if (!is_io)
                    mem_din <= ram[ram_idx];
                else if (hit_in)
                    mem_din <= rx_valid ? rx_data : 8'h00;
                else
                    mem_din <= 8'h00;
            end

            // Pop only on the first cycle of a held RX read so a stalled address consumes one byte.
            prev_rx_read <= rx_read;
            rx_ready     <= rx_read && !prev_rx_read && rx_valid;

            if (mem_wr && (mem_a == IO_END_ADDR))
                program_finish <= 1'b1;

            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_io_responder.sv
// Directed bench for ram_io_responder: RAM read-back, TX FIFO back-pressure and wrap, RX pop strobe,
// end flag and asynchronous reset, each against hand-computed values.
module tb_ram_io_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  mem_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        program_finish;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned pulses;

    ram_io_responder #(
        .RAM_AW     (17),
        .FIFO_DEPTH (4),
        .IO_IN_ADDR (32'h0003_0000),
        .IO_END_ADDR(32'h0003_0004)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_a         (mem_a),
        .mem_wr        (mem_wr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .io_buffer_full(io_buffer_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .program_finish(program_finish)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for sampling.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic wr, input logic [31:0] a, input logic [7:0] d);
        mem_wr   = wr;
        mem_a    = a;
        mem_dout = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        bus(1'b0, 32'h0, 8'h00);
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (2) cyc();
        check("rst_mem_din", mem_din, 8'h00);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_full", io_buffer_full, 1'b0);
        check("rst_rx_ready", rx_ready, 1'b0);
        check("rst_finish", program_finish, 1'b0);
        rst = 1'b1;

        // RAM write then back-to-back reads, plus address wrap above RAM_AW.
        bus(1'b1, 32'h100, 8'hA5); cyc();
        bus(1'b1, 32'h101, 8'h3C); cyc();
        bus(1'b0, 32'h100, 8'h00); cyc();
        check("ram_rd_100", mem_din, 8'hA5);
        bus(1'b0, 32'h101, 8'h00); cyc();
        check("ram_rd_101", mem_din, 8'h3C);
        bus(1'b1, 32'h0002_0100, 8'hC3); cyc();
        bus(1'b0, 32'h100, 8'h00); cyc();
        check("ram_wrap", mem_din, 8'hC3);

        // Fill the FIFO with the sink stalled.
        bus(1'b1, 32'h30000, 8'h11); cyc();
        check("tx_valid_1st", tx_valid, 1'b1);
        check("tx_head_1st", tx_data, 8'h11);
        bus(1'b1, 32'h30000, 8'h22); cyc();
        bus(1'b1, 32'h30000, 8'h33); cyc();
        check("not_full_3", io_buffer_full, 1'b0);
        bus(1'b1, 32'h30000, 8'h44); cyc();
        check("full_4", io_buffer_full, 1'b1);
        bus(1'b1, 32'h30000, 8'h55);
        repeat (3) cyc();
        check("full_held", io_buffer_full, 1'b1);
        check("head_held", tx_data, 8'h11);
        // Drain while 55 is still held: the full cycle's pop must not admit the push.
        tx_ready = 1'b1;
        cyc();
        check("drain_22", tx_data, 8'h22);
        check("full_drop", io_buffer_full, 1'b0);
        cyc();
        bus(1'b0, 32'h0, 8'h00);
        check("drain_33", tx_data, 8'h33);
        cyc();
        check("drain_44", tx_data, 8'h44);
        cyc();
        check("drain_55", tx_data, 8'h55);
        check("drain_55_valid", tx_valid, 1'b1);
        cyc();
        check("drain_empty", tx_valid, 1'b0);

        // Simultaneous push/pop at count 2 across pointer wrap.
        tx_ready = 1'b0;
        bus(1'b1, 32'h30000, 8'h61); cyc();
        bus(1'b1, 32'h30000, 8'h62); cyc();
        check("pp_count2", dut.count, 2);
        tx_ready = 1'b1;
        bus(1'b1, 32'h30000, 8'h63); cyc();
        check("pp_count_a", dut.count, 2);
        check("pp_head_a", tx_data, 8'h62);
        bus(1'b1, 32'h30000, 8'h64); cyc();
        check("pp_count_b", dut.count, 2);
        check("pp_head_b", tx_data, 8'h63);
        bus(1'b1, 32'h30000, 8'h65); cyc();
        check("pp_head_c", tx_data, 8'h64);
        bus(1'b0, 32'h0, 8'h00); cyc();
        check("pp_head_d", tx_data, 8'h65);
        cyc();
        check("pp_empty", tx_valid, 1'b0);
        tx_ready = 1'b0;

        // RX read held 3 cycles pops once.
        rx_valid = 1'b1;
        rx_data  = 8'h7E;
        pulses   = 0;
        bus(1'b0, 32'h30000, 8'h00);
        cyc();
        check("rx_data", mem_din, 8'h7E);
        check("rx_ready_first", rx_ready, 1'b1);
        pulses += int'(rx_ready);
        repeat (2) begin cyc(); pulses += int'(rx_ready); end
        bus(1'b0, 32'h0, 8'h00);
        cyc(); pulses += int'(rx_ready);
        check("rx_one_pulse", pulses, 1);
        rx_valid = 1'b0;
        pulses   = 0;
        bus(1'b0, 32'h30000, 8'h00);
        repeat (3) begin cyc(); pulses += int'(rx_ready); end
        check("rx_invalid_data", mem_din, 8'h00);
        bus(1'b0, 32'h0, 8'h00);
        cyc(); pulses += int'(rx_ready);
        check("rx_invalid_nopulse", pulses, 0);

        // Other IO read returns zero; other IO write has no FIFO effect.
        bus(1'b0, 32'h100, 8'h00); cyc();
        check("ram_before_io", mem_din, 8'hC3);
        bus(1'b0, 32'h30004, 8'h00); cyc();
        check("io_other_rd", mem_din, 8'h00);
        bus(1'b1, 32'h30008, 8'h99); cyc();
        check("io_other_wr", tx_valid, 1'b0);

        // End flag is sticky.
        bus(1'b1, 32'h30004, 8'h00);
        check("finish_pre", program_finish, 1'b0);
        cyc();
        check("finish_set", program_finish, 1'b1);
        bus(1'b1, 32'h200, 8'h12); cyc();
        bus(1'b0, 32'h200, 8'h00); cyc();
        check("finish_sticky", program_finish, 1'b1);
        check("ram_rd_200", mem_din, 8'h12);

        // Asynchronous reset with 3 bytes queued and non-zero read data.
        bus(1'b1, 32'h30000, 8'hA1); cyc();
        bus(1'b1, 32'h30000, 8'hA2); cyc();
        bus(1'b1, 32'h30000, 8'hA3); cyc();
        bus(1'b0, 32'h100, 8'h00); cyc();
        check("pre_rst_valid", tx_valid, 1'b1);
        check("pre_rst_din", mem_din, 8'hC3);
        #2 rst = 1'b0;
        #1;
        check("arst_tx_valid", tx_valid, 1'b0);
        check("arst_full", io_buffer_full, 1'b0);
        check("arst_mem_din", mem_din, 8'h00);
        check("arst_finish", program_finish, 1'b0);
        #1 rst = 1'b1;
        bus(1'b0, 32'h0, 8'h00); cyc();
        check("post_rst_valid", tx_valid, 1'b0);
        check("post_rst_finish", program_finish, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
